// File: rtl/pio_apb_bridge.sv
// pio_apb_bridge
//   APB3 slave that exposes an RP2040-style PIO register map and turns each
//   access into a one-cycle command on the PIO core's command port.
//   Holds readback shadows, sticky FIFO error flags and sequences the
//   two-cycle RX pull/capture.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   psel/penable/pwrite    APB control
//   paddr[11:0]            byte address (bits [1:0] ignored)
//   pwdata[31:0]           APB write data
//   prdata[31:0]           APB read data
//   pready, pslverr        APB completion / error (combinational)
//   action[3:0]            core command code, one-cycle pulse
//   mindex[1:0], index[4:0], din[31:0]   command operands, held between commands
//   dout[31:0]             core registered data output
//   tx_full/tx_empty/rx_full/rx_empty[3:0]  per-machine FIFO flags
//   rx_level0..3, tx_level0..3 [2:0]        per-machine FIFO levels
module pio_apb_bridge #(
  parameter int unsigned NUM_MACHINES = 4,
  parameter logic [31:0] VERSION      = 32'h0100_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [11:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [3:0]  action,
  output logic [1:0]  mindex,
  output logic [4:0]  index,
  output logic [31:0] din,
  input  logic [31:0] dout,
  input  logic [3:0]  tx_full,
  input  logic [3:0]  tx_empty,
  input  logic [3:0]  rx_full,
  input  logic [3:0]  rx_empty,
  input  logic [2:0]  rx_level0,
  input  logic [2:0]  rx_level1,
  input  logic [2:0]  rx_level2,
  input  logic [2:0]  rx_level3,
  input  logic [2:0]  tx_level0,
  input  logic [2:0]  tx_level1,
  input  logic [2:0]  tx_level2,
  input  logic [2:0]  tx_level3
);

  typedef enum logic [3:0] {
    CMD_NONE = 4'd0, CMD_INSTR = 4'd1, CMD_PEND = 4'd2, CMD_PULL = 4'd3,
    CMD_PUSH = 4'd4, CMD_GRPS  = 4'd5, CMD_EN   = 4'd6, CMD_DIV  = 4'd7,
    CMD_IMM  = 4'd9, CMD_SHIFT = 4'd10
  } cmd_e;

  typedef enum logic [3:0] {
    R_NONE, R_CTRL, R_FSTAT, R_FDEBUG, R_FLEVEL, R_TXF, R_RXF, R_VERSION,
    R_IMEM, R_CLKDIV, R_EXEC, R_SHIFT, R_ADDR, R_SMINSTR, R_PINCTRL
  } reg_e;

  typedef enum logic [1:0] {IDLE, PULLW, CAPT, VERW} state_e;

  state_e      state, next_state;
  reg_e        kind;
  logic [1:0]  sel_m;
  logic [4:0]  sel_k;
  logic [9:0]  word, sm_word;
  logic        access, is_err, rd_wait;
  logic [31:0] rdata, prdata_q;
  logic [3:0]  ctrl_sh;
  logic [31:0] clkdiv_sh [4];
  logic [31:0] exec_sh   [4];
  logic [31:0] shift_sh  [4];
  logic [31:0] pinctrl_sh[4];
  logic [3:0]  rxunder, txover;
  logic [3:0]  rx_set, tx_set, rx_clr, tx_clr;
  logic        unused_ok;

  assign unused_ok = &{1'b0, paddr[1:0], VERSION, 32'(NUM_MACHINES)};

  assign word    = paddr[11:2];
  assign sm_word = word - 10'd50;
  // Only IDLE accepts a new access; the wait states belong to an access already decoded.
  assign access  = psel & penable & (state == IDLE);

  // Address decode: register kind plus machine / instruction-slot selectors.
  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    kind  = R_NONE;
    sel_m = '0;
    sel_k = '0;
    if (word == 10'd0)       kind = R_CTRL;
    else if (word == 10'd1)  kind = R_FSTAT;
    else if (word == 10'd2)  kind = R_FDEBUG;
    else if (word == 10'd3)  kind = R_FLEVEL;
    else if (word <= 10'd7)  begin kind = R_TXF; sel_m = word[1:0]; end
    else if (word <= 10'd11) begin kind = R_RXF; sel_m = word[1:0]; end
    else if (word == 10'd12) kind = R_VERSION;
    else if (word >= 10'd18 && word <= 10'd49) begin
      kind  = R_IMEM;
      sel_k = 5'(word - 10'd18);
    end else if (word >= 10'd50 && word <= 10'd73) begin
      sel_m = 2'(sm_word / 10'd6);
      case (3'(sm_word % 10'd6))
        3'd0:    kind = R_CLKDIV;
        3'd1:    kind = R_EXEC;
        3'd2:    kind = R_SHIFT;
        3'd3:    kind = R_ADDR;
        3'd4:    kind = R_SMINSTR;
        3'd5:    kind = R_PINCTRL;
        default: kind = R_NONE;
      endcase
    end
  end

  // Read mux for zero-wait reads; write-only registers fall through to 0.
  always_comb begin
    rdata = '0;
    case (kind)
      R_CTRL:    rdata = {28'h0, ctrl_sh};
      R_FSTAT:   rdata = {4'h0, tx_empty, 4'h0, tx_full, 4'h0, rx_empty, 4'h0, rx_full};
      R_FDEBUG:  rdata = {12'h0, txover, 4'h0, rxunder, 8'h0};
      R_FLEVEL:  rdata = {1'b0, rx_level3, 1'b0, tx_level3, 1'b0, rx_level2, 1'b0, tx_level2,
                          1'b0, rx_level1, 1'b0, tx_level1, 1'b0, rx_level0, 1'b0, tx_level0};
      R_CLKDIV:  rdata = clkdiv_sh[sel_m];
      R_EXEC:    rdata = exec_sh[sel_m];
      R_SHIFT:   rdata = shift_sh[sel_m];
      R_PINCTRL: rdata = pinctrl_sh[sel_m];
      default:   rdata = '0;
    endcase
  end

  assign is_err  = (kind == R_NONE) |
                   (pwrite & (kind inside {R_FSTAT, R_FLEVEL, R_RXF, R_VERSION, R_ADDR}));
  assign rd_wait = !pwrite & (((kind == R_RXF) & !rx_empty[sel_m]) | (kind == R_VERSION));
  assign pslverr = access & is_err;

  // In CAPT/VERW the core's registered dout is returned directly: it only
  // holds the wanted value during this very cycle.
  assign prdata = ((state == CAPT) || (state == VERW)) ? dout : prdata_q;

  always_comb begin
    next_state = state;
    pready     = 1'b0;
    case (state)
      IDLE: begin
        pready = !(access & rd_wait);
        if (access & rd_wait) next_state = (kind == R_VERSION) ? VERW : PULLW;
      end
      PULLW: next_state = CAPT;
      CAPT:  begin pready = 1'b1; next_state = IDLE; end
      VERW:  begin pready = 1'b1; next_state = IDLE; end
      default: next_state = IDLE;
    endcase
    if (reset) pready = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Command port, shadows and registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      action   <= CMD_NONE;
      mindex   <= '0;
      index    <= '0;
      din      <= '0;
      prdata_q <= '0;
      ctrl_sh  <= '0;
      // NOTE: the shadow arrays are reset because software reads them back; the core resets to the same values.
      for (int m = 0; m < 4; m++) begin
        clkdiv_sh[m]  <= '0;
        exec_sh[m]    <= '0;
        shift_sh[m]   <= '0;
        pinctrl_sh[m] <= 32'h1400_0000;
      end
    end else begin
      action <= CMD_NONE;
      if (psel && !penable && (state == IDLE)) prdata_q <= rdata;
      if (access && !is_err) begin
        if (pwrite) begin
          case (kind)
            R_CTRL: begin
              action  <= CMD_EN;
              din     <= {20'h0, pwdata[11:0]};
              ctrl_sh <= pwdata[3:0];
            end
            R_TXF: if (!tx_full[sel_m]) begin
              action <= CMD_PUSH;
              mindex <= sel_m;
              din    <= pwdata;
            end
            R_IMEM: begin
              action <= CMD_INSTR;
              index  <= sel_k;
              din    <= {16'h0, pwdata[15:0]};
            end
            R_CLKDIV: begin
              action           <= CMD_DIV;
              mindex           <= sel_m;
              din              <= {8'h0, pwdata[31:8]};
              clkdiv_sh[sel_m] <= {pwdata[31:8], 8'h0};
            end
            R_EXEC: begin
              action         <= CMD_PEND;
              mindex         <= sel_m;
              din            <= pwdata;
              exec_sh[sel_m] <= pwdata;
            end
            R_SHIFT: begin
              action          <= CMD_SHIFT;
              mindex          <= sel_m;
              din             <= pwdata;
              shift_sh[sel_m] <= pwdata;
            end
            R_SMINSTR: begin
              action <= CMD_IMM;
              mindex <= sel_m;
              din    <= {16'h0, pwdata[15:0]};
            end
            R_PINCTRL: begin
              action            <= CMD_GRPS;
              mindex            <= sel_m;
              din               <= pwdata;
              pinctrl_sh[sel_m] <= pwdata;
            end
            default: ;
          endcase
        end else if ((kind == R_RXF) && !rx_empty[sel_m]) begin
          action <= CMD_PULL;
          mindex <= sel_m;
        end
      end
    end
  end

  // Sticky FIFO error flags; a set event beats a same-cycle W1C.
  always_comb begin
    rx_set = '0;
    tx_set = '0;
    rx_clr = '0;
    tx_clr = '0;
    if (access) begin
      if (!pwrite && (kind == R_RXF) && rx_empty[sel_m]) rx_set[sel_m] = 1'b1;
      if (pwrite && (kind == R_TXF) && tx_full[sel_m])   tx_set[sel_m] = 1'b1;
      if (pwrite && (kind == R_FDEBUG)) begin
        rx_clr = pwdata[11:8];
        tx_clr = pwdata[19:16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rxunder <= '0;
      txover  <= '0;
    end else begin
      rxunder <= (rxunder & ~rx_clr) | rx_set;
      txover  <= (txover & ~tx_clr) | tx_set;
    end
  end

endmodule

// File: tb/tb_pio_apb_bridge.sv
// Self-checking bench for pio_apb_bridge: directed scenarios plus randomized
// accesses scored against a register-level model of the PIO address map.
module tb_pio_apb_bridge;

  localparam logic [31:0] VERSION = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [3:0]  action;
  logic [1:0]  mindex;
  logic [4:0]  index;
  logic [31:0] din;
  logic [31:0] dout = VERSION;
  logic [3:0]  tx_full = 4'h0, tx_empty = 4'hF, rx_full = 4'h0, rx_empty = 4'hF;
  logic [2:0]  txl[4], rxl[4];
  logic [31:0] rx_data[4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pio_apb_bridge #(.NUM_MACHINES(4), .VERSION(VERSION)) dut (
    .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .action(action), .mindex(mindex), .index(index), .din(din), .dout(dout),
    .tx_full(tx_full), .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty),
    .rx_level0(rxl[0]), .rx_level1(rxl[1]), .rx_level2(rxl[2]), .rx_level3(rxl[3]),
    .tx_level0(txl[0]), .tx_level1(txl[1]), .tx_level2(txl[2]), .tx_level3(txl[3])
  );

  // Core stand-in: dout shows the pulled word the cycle after a PULL, VERSION otherwise.
  always @(posedge clk) dout <= (action == 4'd3) ? rx_data[mindex] : VERSION;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
    int          ncmd;
    logic [3:0]  act;
    logic [1:0]  mi;
    logic [4:0]  ix;
    logic [31:0] din;
    logic [31:0] din_after;
  } xact_t;

  typedef struct {
    logic [3:0]  act;
    logic [1:0]  mi;
    logic [4:0]  ix;
    logic [31:0] din;
    logic [31:0] din_after;
  } cmd_t;

  // Command monitor: records each pulse with the din seen one cycle later.
  cmd_t cmd_log[$];
  cmd_t pend_cmd;
  bit   pend = 0, prev_act = 0, dbl = 0;
  always @(negedge clk) begin
    if (pend) begin
      pend_cmd.din_after = din;
      cmd_log.push_back(pend_cmd);
      pend = 0;
    end
    if (action != 4'd0) begin
      if (prev_act) dbl = 1;
      pend_cmd.act = action;
      pend_cmd.mi  = mindex;
      pend_cmd.ix  = index;
      pend_cmd.din = din;
      pend = 1;
    end
    prev_act = (action != 4'd0);
  end

  // Register-level reference model.
  logic [3:0]  m_ctrl, m_rxu, m_txo;
  logic [31:0] m_clk[4], m_exec[4], m_shift[4], m_pin[4];
  logic [1:0]  m_mi;
  logic [4:0]  m_ix;
  logic [31:0] m_din;

  function automatic void model_reset();
    m_ctrl = '0; m_rxu = '0; m_txo = '0; m_mi = '0; m_ix = '0; m_din = '0;
    for (int i = 0; i < 4; i++) begin
      m_clk[i] = '0; m_exec[i] = '0; m_shift[i] = '0; m_pin[i] = 32'h1400_0000;
    end
  endfunction

  function automatic xact_t model(input logic [11:0] a, input bit w, input logic [31:0] wd);
    xact_t e;
    int word, m, r;
    word = int'(a[11:2]);
    e.rd = '0; e.err = 0; e.cyc = 1; e.ncmd = 0; e.act = '0;
    e.mi = m_mi; e.ix = m_ix; e.din = m_din;
    if (word == 0) begin
      if (w) begin e.ncmd = 1; e.act = 4'd6; e.din = wd & 32'hFFF; m_ctrl = wd[3:0]; end
      else e.rd = {28'h0, m_ctrl};
    end else if (word == 1) begin
      if (w) e.err = 1;
      else for (int i = 0; i < 4; i++) begin
        e.rd[i] = rx_full[i]; e.rd[8+i] = rx_empty[i];
        e.rd[16+i] = tx_full[i]; e.rd[24+i] = tx_empty[i];
      end
    end else if (word == 2) begin
      if (w) begin m_rxu = m_rxu & ~wd[11:8]; m_txo = m_txo & ~wd[19:16]; end
      else e.rd = (32'(m_rxu) << 8) | (32'(m_txo) << 16);
    end else if (word == 3) begin
      if (w) e.err = 1;
      else for (int i = 0; i < 4; i++) begin
        e.rd[8*i +: 3] = txl[i]; e.rd[8*i+4 +: 3] = rxl[i];
      end
    end else if (word >= 4 && word <= 7) begin
      m = word - 4;
      if (w) begin
        if (tx_full[m]) m_txo[m] = 1'b1;
        else begin e.ncmd = 1; e.act = 4'd4; e.mi = 2'(m); e.din = wd; end
      end
    end else if (word >= 8 && word <= 11) begin
      m = word - 8;
      if (w) e.err = 1;
      else if (rx_empty[m]) m_rxu[m] = 1'b1;
      else begin e.cyc = 3; e.rd = rx_data[m]; e.ncmd = 1; e.act = 4'd3; e.mi = 2'(m); end
    end else if (word == 12) begin
      if (w) e.err = 1;
      else begin e.cyc = 2; e.rd = VERSION; end
    end else if (word >= 18 && word <= 49) begin
      if (w) begin e.ncmd = 1; e.act = 4'd1; e.ix = 5'(word - 18); e.din = wd & 32'hFFFF; end
    end else if (word >= 50 && word <= 73) begin
      m = (word - 50) / 6;
      r = (word - 50) % 6;
      case (r)
        0: if (w) begin e.ncmd = 1; e.act = 4'd7; e.mi = 2'(m); e.din = wd >> 8; m_clk[m] = wd & 32'hFFFF_FF00; end
           else e.rd = m_clk[m];
        1: if (w) begin e.ncmd = 1; e.act = 4'd2; e.mi = 2'(m); e.din = wd; m_exec[m] = wd; end
           else e.rd = m_exec[m];
        2: if (w) begin e.ncmd = 1; e.act = 4'd10; e.mi = 2'(m); e.din = wd; m_shift[m] = wd; end
           else e.rd = m_shift[m];
        3: if (w) e.err = 1;
        4: if (w) begin e.ncmd = 1; e.act = 4'd9; e.mi = 2'(m); e.din = wd & 32'hFFFF; end
        default: if (w) begin e.ncmd = 1; e.act = 4'd5; e.mi = 2'(m); e.din = wd; m_pin[m] = wd; end
                 else e.rd = m_pin[m];
      endcase
    end else e.err = 1;
    if (e.ncmd == 1) begin m_mi = e.mi; m_ix = e.ix; m_din = e.din; end
    e.din_after = e.din;
    return e;
  endfunction

  // One APB transfer; returns what the DUT did and what the model expects.
  task automatic apb_access(input logic [11:0] a, input bit w, input logic [31:0] wd,
                            output xact_t o, output xact_t e);
    int n;
    e = model(a, w, wd);
    cmd_log.delete();
    dbl = 0;
    @(posedge clk); #1;
    psel = 1; penable = 0; paddr = a; pwrite = w; pwdata = wd;
    @(posedge clk); #1;
    penable = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pready && n < 16);
    checks++;
    if (!pready) begin
      failures++;
      $display("FAIL timeout addr=%h: pready not seen after %0d cycles, required within 3", a, n);
    end
    o.rd = prdata; o.err = pslverr; o.cyc = n;
    @(posedge clk); #1;
    psel = 0; penable = 0;
    repeat (3) @(negedge clk);
    o.ncmd = cmd_log.size();
    o.act = '0; o.mi = '0; o.ix = '0; o.din = '0; o.din_after = '0;
    if (o.ncmd > 0) begin
      o.act = cmd_log[0].act; o.mi = cmd_log[0].mi; o.ix = cmd_log[0].ix;
      o.din = cmd_log[0].din; o.din_after = cmd_log[0].din_after;
    end
  endtask

  task automatic test_reset();
    xact_t o, e;
    reset = 1; psel = 0; penable = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (pready !== 1'b0) begin failures++; $display("FAIL reset_pready: got %b, expected 0", pready); end
    checks++; if (action !== 4'd0) begin failures++; $display("FAIL reset_action: got %0d, expected 0", action); end
    checks++; if (prdata !== 32'h0) begin failures++; $display("FAIL reset_prdata: got %h, expected 0", prdata); end
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    apb_access(12'h0DC, 0, 0, o, e);
    checks++; if (o.rd !== 32'h1400_0000) begin failures++; $display("FAIL reset_pinctrl: got %h, expected 14000000", o.rd); end
    apb_access(12'h000, 0, 0, o, e);
    checks++; if (o.rd !== 32'h0) begin failures++; $display("FAIL reset_ctrl: got %h, expected 0", o.rd); end
    apb_access(12'h008, 0, 0, o, e);
    checks++; if (o.rd !== 32'h0) begin failures++; $display("FAIL reset_fdebug: got %h, expected 0", o.rd); end
  endtask

  task automatic test_tx_push();
    xact_t o, e;
    tx_full = 4'h0;
    apb_access(12'h010, 1, 32'hDEAD_BEEF, o, e);
    checks++; if (o.ncmd !== 1) begin failures++; $display("FAIL push_count: got %0d pulses, expected 1", o.ncmd); end
    checks++; if (o.act !== 4'd4 || o.mi !== 2'd0) begin failures++; $display("FAIL push_cmd: got action=%0d mindex=%0d, expected 4/0", o.act, o.mi); end
    checks++; if (o.din !== 32'hDEAD_BEEF || o.din_after !== 32'hDEAD_BEEF) begin failures++; $display("FAIL push_din: got %h then %h, expected deadbeef held", o.din, o.din_after); end
    checks++; if (dbl !== 1'b0) begin failures++; $display("FAIL push_width: got multi-cycle pulse, expected one cycle"); end
    checks++; if (o.cyc !== 1 || o.err !== 1'b0) begin failures++; $display("FAIL push_resp: got cyc=%0d err=%b, expected 1/0", o.cyc, o.err); end
  endtask

  task automatic test_rx_pull();
    xact_t o, e;
    rx_empty = 4'b1011;
    rx_data[2] = 32'h1234_5678;
    apb_access(12'h028, 0, 0, o, e);
    checks++; if (o.cyc !== 3) begin failures++; $display("FAIL pull_cycles: got %0d, expected 3", o.cyc); end
    checks++; if (o.rd !== 32'h1234_5678) begin failures++; $display("FAIL pull_data: got %h, expected 12345678", o.rd); end
    checks++; if (o.ncmd !== 1 || o.act !== 4'd3 || o.mi !== 2'd2) begin failures++; $display("FAIL pull_cmd: got n=%0d action=%0d mindex=%0d, expected 1/3/2", o.ncmd, o.act, o.mi); end
  endtask

  task automatic test_error_flags();
    xact_t o, e;
    rx_empty = 4'b0010;
    apb_access(12'h024, 0, 0, o, e);
    checks++; if (o.rd !== 32'h0 || o.ncmd !== 0 || o.cyc !== 1) begin failures++; $display("FAIL underflow_read: got rd=%h n=%0d cyc=%0d, expected 0/0/1", o.rd, o.ncmd, o.cyc); end
    apb_access(12'h008, 0, 0, o, e);
    checks++; if (o.rd !== 32'h0000_0200) begin failures++; $display("FAIL rxunder_flag: got %h, expected 00000200", o.rd); end
    tx_full = 4'b1000;
    apb_access(12'h01C, 1, 32'h5555_AAAA, o, e);
    checks++; if (o.ncmd !== 0 || o.err !== 1'b0) begin failures++; $display("FAIL overflow_write: got n=%0d err=%b, expected 0/0", o.ncmd, o.err); end
    apb_access(12'h008, 0, 0, o, e);
    checks++; if (o.rd !== 32'h0008_0200) begin failures++; $display("FAIL txover_flag: got %h, expected 00080200", o.rd); end
    apb_access(12'h008, 1, 32'h0000_0200, o, e);
    apb_access(12'h008, 0, 0, o, e);
    checks++; if (o.rd !== 32'h0008_0000) begin failures++; $display("FAIL w1c: got %h, expected 00080000", o.rd); end
  endtask

  task automatic test_clkdiv_imem();
    xact_t o, e;
    apb_access(12'h0E0, 1, 32'h0003_0100, o, e);
    checks++; if (o.act !== 4'd7 || o.mi !== 2'd1 || o.din !== 32'h0000_0301) begin failures++; $display("FAIL clkdiv_cmd: got action=%0d mindex=%0d din=%h, expected 7/1/00000301", o.act, o.mi, o.din); end
    apb_access(12'h0E0, 0, 0, o, e);
    checks++; if (o.rd !== 32'h0003_0100) begin failures++; $display("FAIL clkdiv_readback: got %h, expected 00030100", o.rd); end
    apb_access(12'h0C4, 1, 32'h0000_E081, o, e);
    checks++; if (o.act !== 4'd1 || o.ix !== 5'd31 || o.din !== 32'h0000_E081) begin failures++; $display("FAIL imem_cmd: got action=%0d index=%0d din=%h, expected 1/31/0000e081", o.act, o.ix, o.din); end
  endtask

  task automatic test_errors();
    xact_t o, e;
    apb_access(12'h004, 1, 32'hFFFF_FFFF, o, e);
    checks++; if (o.err !== 1'b1 || o.ncmd !== 0) begin failures++; $display("FAIL ro_write: got err=%b n=%0d, expected 1/0", o.err, o.ncmd); end
    apb_access(12'h200, 0, 0, o, e);
    checks++; if (o.err !== 1'b1) begin failures++; $display("FAIL unmapped_read: got err=%b, expected 1", o.err); end
    apb_access(12'h0D4, 1, 32'h1, o, e);
    checks++; if (o.err !== 1'b1 || o.ncmd !== 0) begin failures++; $display("FAIL addr_write: got err=%b n=%0d, expected 1/0", o.err, o.ncmd); end
  endtask

  task automatic test_reset_mid_read();
    xact_t o, e;
    apb_access(12'h000, 1, 32'h5, o, e);
    rx_empty = 4'b0000;
    rx_data[2] = 32'hCAFE_0002;
    @(posedge clk); #1;
    psel = 1; penable = 0; paddr = 12'h028; pwrite = 0;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    reset = 1; psel = 0; penable = 0;
    @(negedge clk);
    checks++; if (action !== 4'd3 || pready !== 1'b0) begin failures++; $display("FAIL pullw_state: got action=%0d pready=%b, expected 3/0", action, pready); end
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    checks++; if (action !== 4'd0 || prdata !== 32'h0 || pready !== 1'b1) begin failures++; $display("FAIL after_reset: got action=%0d prdata=%h pready=%b, expected 0/0/1", action, prdata, pready); end
    model_reset();
    repeat (2) @(negedge clk);
    apb_access(12'h000, 0, 0, o, e);
    checks++; if (o.rd !== 32'h0 || o.cyc !== 1) begin failures++; $display("FAIL ctrl_after_reset: got %h cyc=%0d, expected 0/1", o.rd, o.cyc); end
  endtask

  task automatic test_random();
    xact_t o, e;
    logic [9:0]  word;
    logic [11:0] a;
    bit          w;
    for (int it = 0; it < 250; it++) begin
      rx_empty = 4'($urandom); rx_full = 4'($urandom);
      tx_full  = 4'($urandom); tx_empty = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        txl[i] = 3'($urandom); rxl[i] = 3'($urandom); rx_data[i] = $urandom;
      end
      word = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 80));
      a = {word, 2'($urandom)};
      w = 1'($urandom);
      apb_access(a, w, $urandom, o, e);
      if (!w) begin
        checks++; if (o.rd !== e.rd) begin failures++; $display("FAIL rnd_rdata addr=%h: got %h, expected %h", a, o.rd, e.rd); end
      end
      checks++; if (o.err !== e.err) begin failures++; $display("FAIL rnd_err addr=%h w=%b: got %b, expected %b", a, w, o.err, e.err); end
      checks++; if (o.cyc !== e.cyc) begin failures++; $display("FAIL rnd_cycles addr=%h w=%b: got %0d, expected %0d", a, w, o.cyc, e.cyc); end
      checks++; if (o.ncmd !== e.ncmd) begin failures++; $display("FAIL rnd_ncmd addr=%h w=%b: got %0d, expected %0d", a, w, o.ncmd, e.ncmd); end
      if (o.ncmd == 1 && e.ncmd == 1) begin
        checks++;
        if (o.act !== e.act || o.mi !== e.mi || o.ix !== e.ix || o.din !== e.din || o.din_after !== e.din_after) begin
          failures++;
          $display("FAIL rnd_cmd addr=%h: got %0d/%0d/%0d/%h/%h, expected %0d/%0d/%0d/%h/%h",
                   a, o.act, o.mi, o.ix, o.din, o.din_after, e.act, e.mi, e.ix, e.din, e.din_after);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      txl[i] = '0; rxl[i] = '0; rx_data[i] = '0;
    end
    model_reset();
    test_reset();
    test_tx_push();
    test_rx_pull();
    test_error_flags();
    test_clkdiv_imem();
    test_errors();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
